alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: runs one 32-bit ALU operation as one or two passes through an external 16-bit ALU,
// with a valid/ready request side and a valid/ready response side.
package alu_seq_pkg;
  typedef logic [3:0] cs_alu_op;
  localparam cs_alu_op ALU_ADD    = 4'd0;
  localparam cs_alu_op ALU_SUB    = 4'd1;
  localparam cs_alu_op ALU_PLUS_4 = 4'd2;
  localparam cs_alu_op ALU_AND    = 4'd3;
  localparam cs_alu_op ALU_OR     = 4'd4;
  localparam cs_alu_op ALU_XOR    = 4'd5;
  localparam cs_alu_op ALU_EQ     = 4'd6;
  localparam cs_alu_op ALU_LT     = 4'd7;
  localparam cs_alu_op ALU_LTU    = 4'd8;
  localparam cs_alu_op ALU_SLL    = 4'd9;
  localparam cs_alu_op ALU_SRL    = 4'd10;
  localparam cs_alu_op ALU_SRA    = 4'd11;
endpackage

module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  cs_alu_op    req_op_i,
  input  logic        req_cmp_flip_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic        resp_cmp_o,
  output cs_alu_op    alu_op_o,
  output logic        alu_cmp_flip_o,
  output logic        alu_first_cycle_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_cmp_result_i,
  input  logic        alu_cmp_valid_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  cs_alu_op    op_r;
  logic        flip_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] res_r;
  logic        cmp_r;

  logic accept_s;
  logic is_shift_s;
  logic is_cmp_s;
  logic hi_first_s;
  logic big_shift_s;
  logic early_exit_s;
  logic use_hi_s;
  logic alu_busy_s;

  assign req_ready_o    = (state_r == ST_IDLE);
  assign resp_valid_o   = (state_r == ST_DONE);
  assign resp_result_o  = res_r;
  assign resp_cmp_o     = cmp_r;
  assign alu_op_o       = op_r;
  assign alu_cmp_flip_o = flip_r;

  assign accept_s   = req_valid_i & req_ready_o;
  assign alu_busy_s = (state_r == ST_FIRST) | (state_r == ST_SECOND);

  // Operation class decode; right shifts start on the high half
  always_comb begin
    is_shift_s = 1'b0;
    is_cmp_s   = 1'b0;
    hi_first_s = 1'b0;
    case (op_r)
      ALU_SLL: begin
        is_shift_s = 1'b1;
      end
      ALU_SRL, ALU_SRA: begin
        is_shift_s = 1'b1;
        hi_first_s = 1'b1;
      end
      ALU_EQ, ALU_LT, ALU_LTU: begin
        is_cmp_s = 1'b1;
      end
      default: begin
        is_shift_s = 1'b0;
        is_cmp_s   = 1'b0;
        hi_first_s = 1'b0;
      end
    endcase
  end

  // A shift of 16 or more only moves one half, and a low-half EQ mismatch settles the compare
  assign big_shift_s  = is_shift_s & b_r[4];
  assign early_exit_s = big_shift_s | ((op_r == ALU_EQ) & alu_cmp_valid_i);
  assign use_hi_s     = (state_r == ST_FIRST) ? hi_first_s : ~hi_first_s;

  // Next-state logic; flush overrides accept and transfer
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_next_s = ST_FIRST;
          else          state_next_s = ST_IDLE;
        end
        ST_FIRST: begin
          if (early_exit_s) state_next_s = ST_DONE;
          else              state_next_s = ST_SECOND;
        end
        ST_SECOND: begin
          state_next_s = ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready_i) state_next_s = ST_IDLE;
          else              state_next_s = ST_DONE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Operand half selection towards the 16-bit ALU
  always_comb begin
    alu_a_o           = 16'h0000;
    alu_b_o           = 16'h0000;
    alu_first_cycle_o = (state_r == ST_FIRST);
    if (alu_busy_s) begin
      if (big_shift_s) begin
        alu_a_o = (op_r == ALU_SLL) ? a_r[15:0] : a_r[31:16];
        alu_b_o = {12'h000, b_r[3:0]};
      end else if (is_shift_s) begin
        alu_a_o = use_hi_s ? a_r[31:16] : a_r[15:0];
        alu_b_o = {11'h000, b_r[4:0]};
      end else begin
        alu_a_o = use_hi_s ? a_r[31:16] : a_r[15:0];
        alu_b_o = use_hi_s ? b_r[31:16] : b_r[15:0];
      end
    end else begin
      alu_a_o = 16'h0000;
      alu_b_o = 16'h0000;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Request capture and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= ALU_ADD;
      flip_r <= 1'b0;
      a_r    <= 32'h0000_0000;
      b_r    <= 32'h0000_0000;
      res_r  <= 32'h0000_0000;
      cmp_r  <= 1'b0;
    end else if (flush_i) begin
      res_r <= 32'h0000_0000;
      cmp_r <= 1'b0;
    end else if (accept_s) begin
      op_r   <= req_op_i;
      flip_r <= req_cmp_flip_i;
      a_r    <= req_a_i;
      b_r    <= req_b_i;
      res_r  <= 32'h0000_0000;
      cmp_r  <= 1'b0;
    end else if (alu_busy_s) begin
      if (is_cmp_s) begin
        if ((state_r == ST_SECOND) || early_exit_s) begin
          res_r <= {31'h0000_0000, alu_cmp_result_i};
          cmp_r <= alu_cmp_result_i;
        end
      end else if (big_shift_s) begin
        case (op_r)
          ALU_SLL: res_r <= {alu_result_i, 16'h0000};
          ALU_SRA: res_r <= {{16{a_r[31]}}, alu_result_i};
          default: res_r <= {16'h0000, alu_result_i};
        endcase
      end else if (use_hi_s) begin
        res_r[31:16] <= alu_result_i;
      end else begin
        res_r[15:0] <= alu_result_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a companion 16-bit ALU model feeds the DUT, and full 32-bit results
// are checked against plain 32-bit arithmetic.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  cs_alu_op    req_op_i = 4'd0;
  logic        req_cmp_flip_i = 1'b0;
  logic [31:0] req_a_i = 32'h0;
  logic [31:0] req_b_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_result_o;
  logic        resp_cmp_o;
  cs_alu_op    alu_op_o;
  logic        alu_cmp_flip_o;
  logic        alu_first_cycle_o;
  logic [15:0] alu_a_o;
  logic [15:0] alu_b_o;
  logic [15:0] alu_result_i;
  logic        alu_cmp_result_i;
  logic        alu_cmp_valid_i;

  int checks = 0;
  int passed = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_cmp_flip_i(req_cmp_flip_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_cmp_o(resp_cmp_o),
    .alu_op_o(alu_op_o), .alu_cmp_flip_o(alu_cmp_flip_o), .alu_first_cycle_o(alu_first_cycle_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_cmp_result_i(alu_cmp_result_i), .alu_cmp_valid_i(alu_cmp_valid_i)
  );

  always #5 clk = ~clk;

  // Companion 16-bit ALU: carry, cross-half shift bits and low-half ordering persist from the first pass
  logic               m_carry;
  logic               m_lo_lt;
  logic [15:0]        m_spill;
  logic [15:0]        m_spill_nx;
  logic [16:0]        m_sum;
  logic [31:0]        m_wl;
  logic [31:0]        m_wr;
  logic signed [15:0] m_sra;

  always_comb begin
    m_sum            = 17'h0;
    m_sra            = $signed(alu_a_o) >>> alu_b_o[3:0];
    m_wl             = {16'h0, alu_a_o} << alu_b_o[3:0];
    m_wr             = {alu_a_o, 16'h0} >> alu_b_o[3:0];
    m_spill_nx       = (alu_op_o == ALU_SLL) ? m_wl[31:16] : m_wr[15:0];
    alu_result_i     = 16'h0;
    alu_cmp_result_i = 1'b0;
    alu_cmp_valid_i  = 1'b0;
    case (alu_op_o)
      ALU_ADD: begin
        m_sum = {1'b0, alu_a_o} + {1'b0, alu_b_o} + (alu_first_cycle_o ? 17'd0 : {16'd0, m_carry});
        alu_result_i = m_sum[15:0];
      end
      ALU_SUB: begin
        m_sum = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + (alu_first_cycle_o ? 17'd1 : {16'd0, m_carry});
        alu_result_i = m_sum[15:0];
      end
      ALU_PLUS_4: begin
        m_sum = {1'b0, alu_a_o} + (alu_first_cycle_o ? 17'd4 : {16'd0, m_carry});
        alu_result_i = m_sum[15:0];
      end
      ALU_AND: alu_result_i = alu_a_o & alu_b_o;
      ALU_OR:  alu_result_i = alu_a_o | alu_b_o;
      ALU_XOR: alu_result_i = alu_a_o ^ alu_b_o;
      ALU_EQ: begin
        alu_cmp_valid_i  = alu_first_cycle_o & (alu_a_o != alu_b_o);
        alu_cmp_result_i = alu_first_cycle_o ? alu_cmp_flip_o : ((alu_a_o == alu_b_o) ^ alu_cmp_flip_o);
      end
      ALU_LT: begin
        alu_cmp_valid_i  = alu_first_cycle_o;
        alu_cmp_result_i = alu_first_cycle_o ? ~alu_cmp_flip_o :
          ((($signed(alu_a_o) < $signed(alu_b_o)) | ((alu_a_o == alu_b_o) & m_lo_lt)) ^ alu_cmp_flip_o);
      end
      ALU_LTU: begin
        alu_cmp_valid_i  = alu_first_cycle_o;
        alu_cmp_result_i = alu_first_cycle_o ? ~alu_cmp_flip_o :
          (((alu_a_o < alu_b_o) | ((alu_a_o == alu_b_o) & m_lo_lt)) ^ alu_cmp_flip_o);
      end
      ALU_SLL: alu_result_i = (alu_a_o << alu_b_o[3:0]) | (alu_first_cycle_o ? 16'h0 : m_spill);
      ALU_SRL: alu_result_i = (alu_a_o >> alu_b_o[3:0]) | (alu_first_cycle_o ? 16'h0 : m_spill);
      ALU_SRA: alu_result_i = alu_first_cycle_o ? m_sra : ((alu_a_o >> alu_b_o[3:0]) | m_spill);
      default: alu_result_i = alu_first_cycle_o ? (alu_a_o ^ alu_b_o) : (alu_a_o + alu_b_o);
    endcase
  end

  always @(posedge clk) begin
    if (alu_first_cycle_o) begin
      m_carry <= m_sum[16];
      m_lo_lt <= (alu_a_o < alu_b_o);
      m_spill <= m_spill_nx;
    end
  end

  // 32-bit reference: result, compare outcome and cycles from accept to response valid
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic flip, output logic [31:0] res, output logic cmp,
                                    output int lat);
    logic [4:0] s;
    s   = b[4:0];
    res = 32'h0;
    cmp = 1'b0;
    lat = 3;
    case (op)
      ALU_ADD:    res = a + b;
      ALU_SUB:    res = a - b;
      ALU_PLUS_4: res = a + 32'd4;
      ALU_AND:    res = a & b;
      ALU_OR:     res = a | b;
      ALU_XOR:    res = a ^ b;
      ALU_EQ: begin
        cmp = (a == b) ^ flip;
        if (a[15:0] != b[15:0]) lat = 2;
      end
      ALU_LT:  cmp = ($signed(a) < $signed(b)) ^ flip;
      ALU_LTU: cmp = (a < b) ^ flip;
      ALU_SLL: begin res = a << s; if (s >= 5'd16) lat = 2; end
      ALU_SRL: begin res = a >> s; if (s >= 5'd16) lat = 2; end
      ALU_SRA: begin res = $unsigned($signed(a) >>> s); if (s >= 5'd16) lat = 2; end
      default: res = {a[31:16] + b[31:16], a[15:0] ^ b[15:0]};
    endcase
    if (op == ALU_EQ || op == ALU_LT || op == ALU_LTU) res = {31'h0, cmp};
  endfunction

  // Drives one request and collects what the DUT produced; takes the response when it appears
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic flip, output logic [31:0] res, output logic cmp,
                        output int lat, output int firsts, output logic [15:0] fa,
                        output logic [15:0] fb);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!req_ready_o && wait_cnt < 8) begin
      @(negedge clk);
      wait_cnt++;
    end
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_cmp_flip_i = flip;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 1;
    firsts = alu_first_cycle_o ? 1 : 0;
    fa = alu_a_o;
    fb = alu_b_o;
    while (!resp_valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (alu_first_cycle_o) firsts++;
    end
    res = resp_result_o;
    cmp = resp_cmp_o;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_result_o !== 32'h0 ||
        resp_cmp_o !== 1'b0 || alu_first_cycle_o !== 1'b0 || alu_a_o !== 16'h0 ||
        alu_b_o !== 16'h0 || alu_op_o !== 4'd0) begin
      $display("FAIL reset: ready=%b valid=%b res=%h cmp=%b first=%b a=%h b=%h op=%0d required 1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o, alu_first_cycle_o,
               alu_a_o, alu_b_o, alu_op_o);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flip;
    logic [31:0] res;
    logic        cmp;
    int          lat;
    logic [15:0] fa;
    logic [15:0] fb;
  } vec_t;

  task automatic test_directed();
    vec_t        v [11];
    logic [31:0] res;
    logic        cmp;
    int          lat, firsts;
    logic [15:0] fa, fb;
    v[0]  = '{ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 3, 16'hFFFF, 16'h0001};
    v[1]  = '{ALU_SRA, 32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 1'b0, 3, 16'h8000, 16'h0004};
    v[2]  = '{ALU_SRL, 32'h12345678, 32'h00000014, 1'b0, 32'h00000123, 1'b0, 2, 16'h1234, 16'h0004};
    v[3]  = '{ALU_SLL, 32'h00001234, 32'h00000010, 1'b0, 32'h12340000, 1'b0, 2, 16'h1234, 16'h0000};
    v[4]  = '{ALU_EQ,  32'h00000001, 32'h00000002, 1'b0, 32'h00000000, 1'b0, 2, 16'h0001, 16'h0002};
    v[5]  = '{ALU_EQ,  32'h00000001, 32'h00000002, 1'b1, 32'h00000001, 1'b1, 2, 16'h0001, 16'h0002};
    v[6]  = '{ALU_EQ,  32'hDEAD0000, 32'hDEAD0000, 1'b0, 32'h00000001, 1'b1, 3, 16'h0000, 16'h0000};
    v[7]  = '{ALU_LT,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b1, 3, 16'hFFFF, 16'h0001};
    v[8]  = '{ALU_LTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 3, 16'hFFFF, 16'h0001};
    v[9]  = '{ALU_SUB, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 3, 16'h0000, 16'h0001};
    v[10] = '{4'd13,   32'h00050003, 32'h00020006, 1'b0, 32'h00070005, 1'b0, 3, 16'h0003, 16'h0006};
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].flip, res, cmp, lat, firsts, fa, fb);
      checks++;
      if (res !== v[i].res || cmp !== v[i].cmp) begin
        $display("FAIL directed[%0d] result: got %h/%b required %h/%b", i, res, cmp, v[i].res, v[i].cmp);
      end else passed++;
      checks++;
      if (lat !== v[i].lat || firsts !== 1) begin
        $display("FAIL directed[%0d] timing: latency %0d first_cycles %0d required %0d and 1",
                 i, lat, firsts, v[i].lat);
      end else passed++;
      checks++;
      if (fa !== v[i].fa || fb !== v[i].fb) begin
        $display("FAIL directed[%0d] first_pass_operands: got %h/%h required %h/%h", i, fa, fb, v[i].fa, v[i].fb);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp_res;
    logic        exp_cmp;
    int          exp_lat, lat;
    a = $urandom; b = $urandom;
    ref_model(ALU_ADD, a, b, 1'b0, exp_res, exp_cmp, exp_lat);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = ALU_ADD; req_a_i = a; req_b_i = b; req_cmp_flip_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid_i = 1'b1; req_op_i = ALU_XOR;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid_o !== 1'b1 || resp_result_o !== exp_res || req_ready_o !== 1'b0) begin
        $display("FAIL backpressure hold %0d: valid=%b res=%h ready=%b required 1 %h 0",
                 i, resp_valid_o, resp_result_o, req_ready_o, exp_res);
      end else passed++;
      @(posedge clk); #1;
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || alu_first_cycle_o !== 1'b0) begin
      $display("FAIL backpressure transfer: valid=%b ready=%b first=%b required 0 1 0",
               resp_valid_o, req_ready_o, alu_first_cycle_o);
    end else passed++;
    req_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = ALU_ADD; req_a_i = 32'h1111_2222; req_b_i = 32'h3333_4444;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL flush_second: valid=%b ready=%b required 0 1", resp_valid_o, req_ready_o);
    end else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid_o !== 1'b0) begin
        $display("FAIL flush_no_resp %0d: valid=%b required 0", i, resp_valid_o);
      end else passed++;
    end
    req_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || alu_first_cycle_o !== 1'b0) begin
      $display("FAIL flush_over_accept: ready=%b first=%b required 1 0", req_ready_o, alu_first_cycle_o);
    end else passed++;
    req_valid_i = 1'b1; req_op_i = ALU_OR;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL flush_done: valid=%b ready=%b required 0 1", resp_valid_o, req_ready_o);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = ALU_SRA; req_a_i = 32'h8765_4321; req_b_i = 32'h0000_0003;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_result_o !== 32'h0 ||
        resp_cmp_o !== 1'b0 || alu_first_cycle_o !== 1'b0 || alu_a_o !== 16'h0 ||
        alu_b_o !== 16'h0 || alu_op_o !== 4'd0) begin
      $display("FAIL reset_mid: ready=%b valid=%b res=%h cmp=%b first=%b a=%h b=%h op=%0d required 1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o, alu_first_cycle_o,
               alu_a_o, alu_b_o, alu_op_o);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        $display("FAIL reset_mid_discard %0d: valid=%b ready=%b required 0 1", i, resp_valid_o, req_ready_o);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b, r, res, exp_res;
    logic        flip, cmp, exp_cmp;
    int          lat, exp_lat, firsts;
    logic [15:0] fa, fb;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; r = $urandom;
      flip = 1'($urandom_range(0, 1));
      if (op == ALU_EQ || op == ALU_LT || op == ALU_LTU) begin
        case ($urandom_range(0, 2))
          0: b = a;
          1: b = {r[31:16], a[15:0]};
          default: b = r;
        endcase
      end
      ref_model(op, a, b, flip, exp_res, exp_cmp, exp_lat);
      run_op(op, a, b, flip, res, cmp, lat, firsts, fa, fb);
      checks++;
      if (res !== exp_res) begin
        $display("FAIL random[%0d] op=%0d a=%h b=%h result: got %h required %h", i, op, a, b, res, exp_res);
      end else passed++;
      checks++;
      if (cmp !== exp_cmp) begin
        $display("FAIL random[%0d] op=%0d cmp: got %b required %b", i, op, cmp, exp_cmp);
      end else passed++;
      checks++;
      if (lat !== exp_lat || firsts !== 1) begin
        $display("FAIL random[%0d] op=%0d timing: latency %0d first_cycles %0d required %0d and 1",
                 i, op, lat, firsts, exp_lat);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
